// File: rtl/vram_pkg.sv
// Shared defaults and grant encoding for the VRAM arbiter slice.
// Imported by vram_arbiter and wr_fifo2.
package vram_pkg;

    localparam int AW_DEF         = 13;
    localparam int DW_DEF         = 8;
    localparam int STARVE_MAX_DEF = 15;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

endpackage

// File: rtl/wr_fifo2.sv
// Two-entry write FIFO holding pending VRAM writes (address + data).
// Ports: clk, h_count_reset (async, active-high), i_push/i_wr_addr/i_wr_data
// (push side), i_pop (pop head), o_ready (not full), o_nempty (has data),
// o_head_addr/o_head_data (oldest entry, combinational).
module wr_fifo2
    import vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          h_count_reset,
    input  logic          i_push,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_pop,
    output logic          o_ready,
    output logic          o_nempty,
    output logic [AW-1:0] o_head_addr,
    output logic [DW-1:0] o_head_data
);

    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_data [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // Full is judged on the registered count only, so a same-cycle pop
    // never opens the door for a push.
    assign o_ready     = (r_count != 2'd2);
    assign o_nempty    = (r_count != 2'd0);
    assign w_do_push   = i_push & o_ready;
    assign w_do_pop    = i_pop & o_nempty;
    assign o_head_addr = r_addr[r_rptr];
    assign o_head_data = r_data[r_rptr];

    always_ff @(posedge clk or posedge h_count_reset) begin
        if (h_count_reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) r_wptr <= ~r_wptr;
            if (w_do_pop)  r_rptr <= ~r_rptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_addr[r_wptr] <= i_wr_addr;
            r_data[r_wptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates a single-port VRAM between display reads and buffered writes.
// Ports: clk, h_count_reset (async, active-high), onscreen, disp_req/addr ->
// disp_gnt/rvalid/rdata, wr_valid/addr/data -> wr_ready, ram_* command out.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          h_count_reset,
    input  logic          onscreen,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic          w_nempty;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic          w_starved;
    gnt_e          w_gnt;

    gnt_e          r_gnt_q;
    logic          r_rvalid;
    logic [SW-1:0] r_starve;

    wr_fifo2 #(
        .AW(AW),
        .DW(DW)
    ) u_fifo (
        .clk          (clk),
        .h_count_reset(h_count_reset),
        .i_push       (wr_valid),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_pop        (w_gnt == GNT_WR),
        .o_ready      (wr_ready),
        .o_nempty     (w_nempty),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data)
    );

    assign w_starved = w_nempty && (r_starve == SMAX);

    // Visible region favours the display until a write has waited too long;
    // blanking favours draining the write FIFO.
    always_comb begin
        w_gnt = GNT_NONE;
        if (onscreen) begin
            if (disp_req && !w_starved) w_gnt = GNT_DISP;
            else if (w_nempty)          w_gnt = GNT_WR;
        end else begin
            if (w_nempty)               w_gnt = GNT_WR;
            else if (disp_req)          w_gnt = GNT_DISP;
        end
    end

    assign disp_gnt    = (w_gnt == GNT_DISP);
    assign disp_rvalid = r_rvalid;
    // RAM data is live in the cycle after the read command; gate it so the
    // bus reads zero whenever no response is due.
    assign disp_rdata  = r_rvalid ? ram_rdata : '0;

    always_ff @(posedge clk or posedge h_count_reset) begin
        if (h_count_reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            r_gnt_q   <= GNT_NONE;
            r_rvalid  <= 1'b0;
            r_starve  <= '0;
        end else begin
            r_gnt_q  <= w_gnt;
            r_rvalid <= (r_gnt_q == GNT_DISP);

            unique case (w_gnt)
                GNT_DISP: begin
                    ram_addr <= disp_addr;
                    ram_we   <= 1'b0;
                end
                GNT_WR: begin
                    ram_addr  <= w_head_addr;
                    ram_wdata <= w_head_data;
                    ram_we    <= 1'b1;
                end
                default: ram_we <= 1'b0;
            endcase

            // Counts display wins only while a write is actually waiting.
            if (w_gnt == GNT_WR || !w_nempty)
                r_starve <= '0;
            else if (w_gnt == GNT_DISP && r_starve != SMAX)
                r_starve <= r_starve + 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous RAM model.
// Inputs change at posedge+1, outputs are checked at posedge+2.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          h_count_reset;
    logic          onscreen;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk          (clk),
        .h_count_reset(h_count_reset),
        .onscreen     (onscreen),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_gnt     (disp_gnt),
        .disp_rvalid  (disp_rvalid),
        .disp_rdata   (disp_rdata),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[13'h0100] = 8'h5A;
        mem[13'h0300] = 8'h77;

        h_count_reset = 1'b1;
        onscreen  = 1'b0;
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_we",     ram_we, 0);
        chk("rst_addr",   ram_addr, 0);
        chk("rst_wdata",  ram_wdata, 0);
        chk("rst_rvalid", disp_rvalid, 0);
        chk("rst_rdata",  disp_rdata, 0);
        chk("rst_ready",  wr_ready, 1);
        chk("rst_gnt",    disp_gnt, 0);
        cyc();
        h_count_reset = 1'b0;
        #1;
        chk("post_rst_ready", wr_ready, 1);

        // Basic onscreen read
        cyc();
        onscreen = 1'b1; disp_req = 1'b1; disp_addr = 13'h0100;
        #1;
        chk("rd_gnt", disp_gnt, 1);
        cyc();
        disp_req = 1'b0;
        #1;
        chk("rd_cmd_addr", ram_addr, 13'h0100);
        chk("rd_cmd_we",   ram_we, 0);
        chk("rd_early_rv", disp_rvalid, 0);
        cyc(); #1;
        chk("rd_rvalid", disp_rvalid, 1);
        chk("rd_rdata",  disp_rdata, 8'h5A);
        cyc(); #1;
        chk("rd_rv_once", disp_rvalid, 0);

        // Blanking: a write beats the display
        cyc();
        onscreen = 1'b0;
        wr_valid = 1'b1; wr_addr = 13'h0200; wr_data = 8'hC3;
        #1;
        chk("bl_ready", wr_ready, 1);
        cyc();
        wr_valid = 1'b0;
        disp_req = 1'b1; disp_addr = 13'h0300;
        #1;
        chk("bl_disp_denied", disp_gnt, 0);
        cyc(); #1;
        chk("bl_wr_we",    ram_we, 1);
        chk("bl_wr_addr",  ram_addr, 13'h0200);
        chk("bl_wr_data",  ram_wdata, 8'hC3);
        chk("bl_disp_gnt", disp_gnt, 1);
        cyc();
        disp_req = 1'b0;
        #1;
        chk("bl_rd_we",   ram_we, 0);
        chk("bl_rd_addr", ram_addr, 13'h0300);
        cyc(); #1;
        chk("bl_rdata", disp_rdata, 8'h77);
        cyc(); cyc();

        // Starvation limit while onscreen
        cyc();
        onscreen = 1'b1;
        disp_req = 1'b1; disp_addr = 13'h0100;
        wr_valid = 1'b1; wr_addr = 13'h0400; wr_data = 8'h11;
        #1;
        chk("sv_first_gnt", disp_gnt, 1);
        cyc();
        wr_valid = 1'b0;
        #1;
        n = 0;
        if (disp_gnt) n++;
        for (int i = 0; i < 14; i++) begin
            cyc(); #1;
            if (disp_gnt) n++;
        end
        chk("sv_disp_wins", n, 15);
        cyc(); #1;
        chk("sv_c16_denied", disp_gnt, 0);
        cyc(); #1;
        chk("sv_wr_we",     ram_we, 1);
        chk("sv_wr_addr",   ram_addr, 13'h0400);
        chk("sv_wr_data",   ram_wdata, 8'h11);
        chk("sv_c17_gnt",   disp_gnt, 1);

        // FIFO full: third write waits, order preserved
        cyc();
        wr_valid = 1'b1; wr_addr = 13'h0500; wr_data = 8'hA1;
        #1;
        chk("ff_ready0", wr_ready, 1);
        cyc();
        wr_addr = 13'h0501; wr_data = 8'hA2;
        #1;
        chk("ff_ready1", wr_ready, 1);
        cyc();
        wr_addr = 13'h0502; wr_data = 8'hA3;
        #1;
        chk("ff_full", wr_ready, 0);
        chk("ff_no_pop", ram_we, 0);
        cyc();
        onscreen = 1'b0; disp_req = 1'b0;
        #1;
        chk("ff_full_pop", wr_ready, 0);
        cyc(); #1;
        chk("ff_ready_again", wr_ready, 1);
        chk("ff_w1_we",   ram_we, 1);
        chk("ff_w1_addr", ram_addr, 13'h0500);
        chk("ff_w1_data", ram_wdata, 8'hA1);
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("ff_w2_addr", ram_addr, 13'h0501);
        chk("ff_w2_data", ram_wdata, 8'hA2);
        cyc(); #1;
        chk("ff_w3_addr", ram_addr, 13'h0502);
        chk("ff_w3_data", ram_wdata, 8'hA3);
        cyc(); #1;
        chk("ff_idle_we", ram_we, 0);

        // Reset with two queued writes and a read in flight
        cyc();
        onscreen = 1'b1;
        disp_req = 1'b1; disp_addr = 13'h0100;
        wr_valid = 1'b1; wr_addr = 13'h0600; wr_data = 8'hB1;
        cyc();
        wr_addr = 13'h0601; wr_data = 8'hB2;
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("mr_full", wr_ready, 0);
        h_count_reset = 1'b1;
        disp_req = 1'b0;
        #1;
        chk("mr_we",     ram_we, 0);
        chk("mr_rvalid", disp_rvalid, 0);
        chk("mr_ready",  wr_ready, 1);
        chk("mr_addr",   ram_addr, 0);
        cyc();
        onscreen = 1'b0;
        h_count_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("mr_no_stale_we", ram_we, 0);
            chk("mr_no_stale_rv", disp_rvalid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
